// File: rtl/nn_dense_layer.sv
// Fully-connected NN layer (forward pass) with one time-shared MAC and a runtime-loadable
// weight/bias file; signed fixed point DATA_W bits with FRAC_W fraction bits.
module nn_dense_layer #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14,
  parameter int ADDR_W = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      start,
  input  logic [1:0]                act_mode,
  input  logic [N_IN*DATA_W-1:0]    x_in,
  input  logic                      w_we,
  input  logic [ADDR_W-1:0]         w_addr,
  input  logic [DATA_W-1:0]         w_data,
  output logic                      busy,
  output logic                      done,
  output logic [N_OUT*DATA_W-1:0]   y_out
);

  localparam int N_W   = N_OUT * (N_IN + 1);
  localparam int ACC_W = 2 * DATA_W + $clog2(N_IN + 2);
  localparam int I_W   = $clog2(N_IN + 1);
  localparam int N_B   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [I_W-1:0]    I_LAST = I_W'(N_IN);
  localparam logic [I_W-1:0]    I_ONE  = I_W'(1);
  localparam logic [N_B-1:0]    N_LAST = N_B'(N_OUT - 1);
  localparam logic [N_B-1:0]    N_ONE  = N_B'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   N_W_C  = (ADDR_W+1)'(N_W);

  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ~SAT_MAX;
  localparam logic signed [DATA_W+1:0] HS_HALF = (DATA_W+2)'(32'sd1 <<< (FRAC_W - 1));
  localparam logic signed [DATA_W+1:0] HS_ONE  = (DATA_W+2)'(32'sd1 <<< FRAC_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     state_r;
  logic                       busy_r;
  logic                       done_r;
  logic [1:0]                 mode_r;
  logic [N_IN*DATA_W-1:0]     x_sh_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic [I_W-1:0]             i_r;
  logic [N_B-1:0]             n_r;
  logic [ADDR_W-1:0]          wptr_r;
  logic [N_OUT*DATA_W-1:0]    y_r;
  logic signed [DATA_W-1:0]   wmem [N_W];

  logic signed [DATA_W-1:0]   w_s;
  logic signed [DATA_W-1:0]   x_s;
  logic [N_IN*DATA_W-1:0]     x_rot_s;
  logic signed [ACC_W-1:0]    prod_s;
  logic signed [ACC_W-1:0]    bias_s;
  logic signed [ACC_W-1:0]    addend_s;
  logic signed [ACC_W-1:0]    acc_sh_s;
  logic signed [DATA_W-1:0]   sat_s;
  logic signed [DATA_W-1:0]   act_s;

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      sat_fn = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      sat_fn = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_fn = v[DATA_W-1:0];
    end
  endfunction

  function automatic logic signed [DATA_W-1:0] act_fn(input logic [1:0] mode,
                                                      input logic signed [DATA_W-1:0] s);
    logic signed [DATA_W+1:0] h_v;
    h_v = (DATA_W+2)'(s >>> 2) + HS_HALF;
    case (mode)
      2'd1: act_fn = s[DATA_W-1] ? {DATA_W{1'b0}} : s;
      2'd2: begin
        if (h_v[DATA_W+1]) begin
          act_fn = {DATA_W{1'b0}};
        end else if (h_v > HS_ONE) begin
          act_fn = HS_ONE[DATA_W-1:0];
        end else begin
          act_fn = h_v[DATA_W-1:0];
        end
      end
      default: act_fn = s;
    endcase
  endfunction

  // The x operand register rotates one lane per product so x[i] is always in the low lane.
  generate
    if (N_IN > 1) begin : g_rot
      assign x_rot_s = {x_sh_r[DATA_W-1:0], x_sh_r[N_IN*DATA_W-1:DATA_W]};
    end else begin : g_rot1
      assign x_rot_s = x_sh_r;
    end
  endgenerate

  assign w_s      = wmem[wptr_r];
  assign x_s      = x_sh_r[DATA_W-1:0];
  assign prod_s   = ACC_W'(w_s) * ACC_W'(x_s);
  assign bias_s   = ACC_W'(w_s) <<< FRAC_W;
  assign addend_s = (i_r == I_LAST) ? bias_s : prod_s;
  assign acc_sh_s = acc_r >>> FRAC_W;
  assign sat_s    = sat_fn(acc_sh_s);
  assign act_s    = act_fn(mode_r, sat_s);

  assign busy  = busy_r;
  assign done  = done_r;
  assign y_out = y_r;

  // Weight file: writable only while idle, out-of-range addresses dropped, never reset.
  always_ff @(posedge clk) begin
    if (w_we && (state_r == S_IDLE) && ({1'b0, w_addr} < N_W_C)) begin
      wmem[w_addr] <= w_data;
    end
  end

  // Sequencer: MAC over N_IN products plus bias, then one activation cycle per neuron.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mode_r  <= 2'd0;
      x_sh_r  <= {(N_IN*DATA_W){1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      i_r     <= {I_W{1'b0}};
      n_r     <= {N_B{1'b0}};
      wptr_r  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            x_sh_r  <= x_in;
            mode_r  <= act_mode;
            acc_r   <= {ACC_W{1'b0}};
            i_r     <= {I_W{1'b0}};
            n_r     <= {N_B{1'b0}};
            wptr_r  <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= S_MAC;
          end
        end
        S_MAC: begin
          acc_r  <= acc_r + addend_s;
          wptr_r <= wptr_r + A_ONE;
          if (i_r == I_LAST) begin
            i_r     <= {I_W{1'b0}};
            state_r <= S_ACT;
          end else begin
            i_r    <= i_r + I_ONE;
            x_sh_r <= x_rot_s;
          end
        end
        S_ACT: begin
          acc_r <= {ACC_W{1'b0}};
          i_r   <= {I_W{1'b0}};
          if (n_r == N_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            n_r     <= n_r + N_ONE;
            state_r <= S_MAC;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Capture the activated value into the current neuron's output slot.
  always_ff @(posedge clk) begin
    if (res) begin
      y_r <= {(N_OUT*DATA_W){1'b0}};
    end else if (state_r == S_ACT) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (n_r == N_B'(k)) begin
          y_r[k*DATA_W +: DATA_W] <= act_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Directed bench for nn_dense_layer: table of 2x2 vectors plus hand sequences for
// reset abort, busy-time filtering and a 4-input/3-neuron build.
module tb_nn_dense_layer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, start, w_we, busy, done;
  logic [1:0]  act_mode;
  logic [31:0] x_in, y_out;
  logic [2:0]  w_addr;
  logic [15:0] w_data;

  logic        start2, w_we2, busy2, done2;
  logic [63:0] x_in2;
  logic [3:0]  w_addr2;
  logic [15:0] w_data2;
  logic [47:0] y_out2;

  int checks = 0;
  int errors = 0;

  nn_dense_layer dut (
    .clk(clk), .res(res), .start(start), .act_mode(act_mode), .x_in(x_in),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .y_out(y_out)
  );

  nn_dense_layer #(.N_IN(4), .N_OUT(3)) dut2 (
    .clk(clk), .res(res), .start(start2), .act_mode(2'd0), .x_in(x_in2),
    .w_we(w_we2), .w_addr(w_addr2), .w_data(w_data2),
    .busy(busy2), .done(done2), .y_out(y_out2)
  );

  typedef struct {
    logic [15:0] w [6];
    logic [15:0] x0, x1;
    logic [1:0]  mode;
    logic [15:0] y0, y1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] w00, w01, b0, w10, w11, b1, x0, x1,
                         input logic [1:0] mode, input logic [15:0] y0, y1);
    vec_t v;
    v.w[0] = w00; v.w[1] = w01; v.w[2] = b0;
    v.w[3] = w10; v.w[4] = w11; v.w[5] = b1;
    v.x0 = x0; v.x1 = x1; v.mode = mode; v.y0 = y0; v.y1 = y1;
    vecs.push_back(v);
  endtask

  task automatic load_w(input logic [15:0] w [6]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = 3'(i); w_data = w[i];
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Start a run (optionally with a same-cycle weight write) and wait for done.
  task automatic start_run(input logic [1:0] m, input logic [15:0] a, b,
                           input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                           output int lat);
    @(negedge clk);
    act_mode = m; x_in = {b, a}; start = 1'b1;
    w_we = wr; w_addr = wa; w_data = wd;
    @(negedge clk);
    start = 1'b0; w_we = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] m, input logic [15:0] a, b,
                           input logic wr, input logic [2:0] wa, input logic [15:0] wd,
                           input logic [15:0] y0e, y1e);
    int lat;
    start_run(m, a, b, wr, wa, wd, lat);
    // start is cycle 0, so done should appear in cycle 2*(2+2)+1
    check({name, " done cycle"}, 64'(lat + 1), 64'd9);
    check({name, " y0"}, 64'(y_out[15:0]), 64'(y0e));
    check({name, " y1"}, 64'(y_out[31:16]), 64'(y1e));
    @(negedge clk);
    check({name, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int dcnt;
    logic [15:0] w2 [15];

    res = 1'b1; start = 1'b0; w_we = 1'b0; act_mode = 2'd0; x_in = 32'd0;
    w_addr = 3'd0; w_data = 16'd0;
    start2 = 1'b0; w_we2 = 1'b0; x_in2 = 64'd0; w_addr2 = 4'd0; w_data2 = 16'd0;

    //      w00       w01       b0        w10       w11       b1        x0        x1        md    y0        y1
    add_vec(16'h2000, 16'h2000, 16'h0000, 16'h2000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 2'd0, 16'h4000, 16'h4000);
    add_vec(16'h2000, 16'h2000, 16'h0000, 16'h2000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 2'd2, 16'h3000, 16'h3000);
    add_vec(16'h2000, 16'h2000, 16'hA000, 16'h2000, 16'h2000, 16'hA000, 16'h4000, 16'h4000, 2'd1, 16'h0000, 16'h0000);
    add_vec(16'h2000, 16'h2000, 16'hA000, 16'h2000, 16'h2000, 16'hA000, 16'h4000, 16'h4000, 2'd2, 16'h1800, 16'h1800);
    add_vec(16'h2000, 16'h2000, 16'hA000, 16'h2000, 16'h2000, 16'hA000, 16'h4000, 16'h4000, 2'd0, 16'hE000, 16'hE000);
    add_vec(16'h2000, 16'h2000, 16'hA000, 16'h2000, 16'h2000, 16'hA000, 16'h4000, 16'h4000, 2'd3, 16'hE000, 16'hE000);
    add_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2'd0, 16'h7FFF, 16'h7FFF);
    add_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 2'd0, 16'h8000, 16'h8000);
    add_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 2'd2, 16'h0000, 16'h0000);
    add_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2'd2, 16'h3FFF, 16'h3FFF);
    add_vec(16'h0001, 16'h0000, 16'h0000, 16'h4000, 16'hC000, 16'h0100, 16'hFFFF, 16'h2000, 2'd0, 16'hFFFF, 16'hE0FF);
    add_vec(16'h0001, 16'h0000, 16'h0000, 16'h4000, 16'hC000, 16'h0100, 16'hFFFF, 16'h2000, 2'd2, 16'h1FFF, 16'h183F);
    add_vec(16'h0001, 16'h0000, 16'h0000, 16'h4000, 16'hC000, 16'h0100, 16'hFFFF, 16'h2000, 2'd1, 16'h0000, 16'h0000);

    repeat (3) @(negedge clk);
    res = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset y_out", 64'(y_out), 64'd0);
    check("reset busy2", 64'(busy2), 64'd0);
    check("reset y_out2", 64'(y_out2), 64'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      load_w(vecs[k].w);
      run_check($sformatf("vec%0d", k), vecs[k].mode, vecs[k].x0, vecs[k].x1,
                1'b0, 3'd0, 16'd0, vecs[k].y0, vecs[k].y1);
    end

    // Write to w[0][0] in the same cycle as start: the run must see the new value.
    load_w(vecs[0].w);
    run_check("wr+start", 2'd0, 16'h4000, 16'h4000, 1'b1, 3'd0, 16'h4000, 16'h6000, 16'h4000);

    // Start, writes and input changes while busy or in DONE are all dropped.
    load_w(vecs[0].w);
    @(negedge clk);
    act_mode = 2'd0; x_in = {16'h4000, 16'h4000}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy || done) begin
        start = 1'b1; w_we = 1'b1; w_addr = 3'd0; w_data = 16'h7FFF;
        x_in = 32'd0; act_mode = 2'd2;
      end else begin
        start = 1'b0; w_we = 1'b0;
      end
    end
    start = 1'b0; w_we = 1'b0;
    check("busy done count", 64'(dcnt), 64'd1);
    check("busy y_out held", 64'(y_out), 64'h4000_4000);
    run_check("after busy", 2'd0, 16'h4000, 16'h4000, 1'b0, 3'd0, 16'd0, 16'h4000, 16'h4000);

    // Out-of-range addresses must not disturb the file.
    @(negedge clk); w_we = 1'b1; w_addr = 3'd6; w_data = 16'h7FFF;
    @(negedge clk); w_addr = 3'd7;
    @(negedge clk); w_we = 1'b0;
    run_check("bad addr", 2'd0, 16'h4000, 16'h4000, 1'b0, 3'd0, 16'd0, 16'h4000, 16'h4000);

    // Reset in cycle 4 of a run aborts it, clears outputs and keeps the weights.
    @(negedge clk);
    act_mode = 2'd0; x_in = {16'h4000, 16'h4000}; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b1;
    @(negedge clk); res = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort y_out", 64'(y_out), 64'd0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort no done", 64'(dcnt), 64'd0);
    run_check("rerun", 2'd0, 16'h4000, 16'h4000, 1'b0, 3'd0, 16'd0, 16'h4000, 16'h4000);

    // 4-input, 3-neuron build: address = n*5+i, bias at i=4.
    w2 = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
           16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0400,
           16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      w_we2 = 1'b1; w_addr2 = 4'(i); w_data2 = w2[i];
    end
    @(negedge clk);
    w_we2 = 1'b0;
    x_in2 = {16'h1000, 16'hC000, 16'h2000, 16'h4000};
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("4x3 done cycle", 64'(lat + 1), 64'd19);
    check("4x3 y0", 64'(y_out2[15:0]), 64'h4000);
    check("4x3 y1", 64'(y_out2[31:16]), 64'h2400);
    check("4x3 y2", 64'(y_out2[47:32]), 64'hD000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
